// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit PRBS checker: LFSR successor,
// FSM states and the hex seven-segment lookup table.
package lfsr_pkg;

    localparam int LFSR_W = 8;

    // Feedback taps: new MSB = s[0] ^ s[2] ^ s[3] ^ s[4]
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b0001_1101;

    typedef enum logic {
        ST_HUNT,
        ST_LOCKED
    } state_e;

    // Active-high segments: bit7=a .. bit1=g, bit0=dp (always off)
    localparam logic [7:0] SEG_HEX [0:15] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2,
        8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E,
        8'h9C, 8'h7A, 8'h9E, 8'h8E
    };

    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] s
    );
        return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/hex_seg_dec.sv
// Registered hex digit decoder driving one active-low seven-segment digit.
// Ports: clk, rst (sync, active-high), nib_i (hex digit), seg_o (a..g,dp low-active).
module hex_seg_dec
    import lfsr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] nib_i,
    output logic [7:0] seg_o
);

    logic [7:0] seg_d;
    logic [7:0] seg_q;

    always_comb begin
        seg_d = ~SEG_HEX[nib_i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= ~SEG_HEX[0];
        end else begin
            seg_q <= seg_d;
        end
    end

    assign seg_o = seg_q;

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side PRBS checker: locks onto an 8-bit LFSR stream, flywheels
// the prediction while locked, counts mismatches and shows the count in hex.
// Ports: clk, rst (sync, active-high), in_valid/in_data (stream beat),
//   clr_err (clear error count and zero flag), locked, err_pulse,
//   err_cnt (saturating), zero_err (sticky), seg0/seg1 (low/high nibble).
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_CNT = 3,
    parameter int LOSS_CNT = 2,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic             zero_err,
    output logic [7:0]       seg0,
    output logic [7:0]       seg1
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);

    state_e             state_q, state_d;
    logic [LFSR_W-1:0]  pred_q, pred_d;
    logic [3:0]         match_q, match_d;
    logic [3:0]         miss_q, miss_d;
    logic               first_q, first_d;
    logic               locked_q, locked_d;
    logic               pulse_q, pulse_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               zero_q, zero_d;

    logic [LFSR_W-1:0]  exp_data;
    logic               is_zero;
    logic               err_inc;

    always_comb begin
        state_d  = state_q;
        pred_d   = pred_q;
        match_d  = match_q;
        miss_d   = miss_q;
        first_d  = first_q;
        pulse_d  = 1'b0;
        err_d    = err_q;
        zero_d   = zero_q;
        err_inc  = 1'b0;
        exp_data = lfsr_next(pred_q);
        is_zero  = (in_data == '0);

        if (in_valid) begin
            if (is_zero) begin
                zero_d = 1'b1;
            end

            unique case (state_q)
                ST_HUNT: begin
                    pred_d  = in_data;
                    first_d = 1'b0;
                    // 00 is a fixed point of the LFSR, so it must never
                    // be mistaken for a correct successor.
                    if (!first_q && !is_zero && in_data == exp_data) begin
                        if (match_q + 4'd1 == LOCK_N) begin
                            state_d = ST_LOCKED;
                            match_d = '0;
                            miss_d  = '0;
                        end else begin
                            match_d = match_q + 4'd1;
                        end
                    end else begin
                        match_d = '0;
                    end
                end

                ST_LOCKED: begin
                    // Flywheel: the prediction ignores received data.
                    pred_d = exp_data;
                    if (in_data == exp_data) begin
                        miss_d = '0;
                    end else begin
                        pulse_d = 1'b1;
                        err_inc = 1'b1;
                        if (miss_q + 4'd1 == LOSS_N) begin
                            state_d = ST_HUNT;
                            match_d = '0;
                            miss_d  = '0;
                            pred_d  = in_data;
                            first_d = 1'b1;
                        end else begin
                            miss_d = miss_q + 4'd1;
                        end
                    end
                end

                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end

        if (err_inc && err_q != '1) begin
            err_d = err_q + 1'b1;
        end

        if (clr_err) begin
            err_d  = '0;
            zero_d = 1'b0;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_HUNT;
            pred_q   <= '0;
            match_q  <= '0;
            miss_q   <= '0;
            first_q  <= 1'b1;
            locked_q <= 1'b0;
            pulse_q  <= 1'b0;
            err_q    <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pred_q   <= pred_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            first_q  <= first_d;
            locked_q <= locked_d;
            pulse_q  <= pulse_d;
            err_q    <= err_d;
            zero_q   <= zero_d;
        end
    end

    // Digits decode the registered count, so they trail err_cnt by a cycle.
    hex_seg_dec u_seg0 (
        .clk   (clk),
        .rst   (rst),
        .nib_i (err_q[3:0]),
        .seg_o (seg0)
    );

    hex_seg_dec u_seg1 (
        .clk   (clk),
        .rst   (rst),
        .nib_i (err_q[7:4]),
        .seg_o (seg1)
    );

    assign locked    = locked_q;
    assign err_pulse = pulse_q;
    assign err_cnt   = err_q;
    assign zero_err  = zero_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: a default instance (A) and an
// 8-bit-counter instance with LOSS_CNT=15 (B) for saturation.
module tb_lfsr_checker;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        sel;
    logic [7:0]  in_data;
    logic        clr_err;

    logic        a_locked, a_pulse, a_zero;
    logic [15:0] a_err;
    logic [7:0]  a_seg0, a_seg1;
    logic        b_locked, b_pulse, b_zero;
    logic [7:0]  b_err;
    logic [7:0]  b_seg0, b_seg1;

    logic        a_valid, b_valid;
    assign a_valid = in_valid & ~sel;
    assign b_valid = in_valid & sel;

    lfsr_checker u_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_valid),
        .in_data   (in_data),
        .clr_err   (clr_err),
        .locked    (a_locked),
        .err_pulse (a_pulse),
        .err_cnt   (a_err),
        .zero_err  (a_zero),
        .seg0      (a_seg0),
        .seg1      (a_seg1)
    );

    lfsr_checker #(
        .LOCK_CNT (3),
        .LOSS_CNT (15),
        .ERR_W    (8)
    ) u_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_valid),
        .in_data   (in_data),
        .clr_err   (clr_err),
        .locked    (b_locked),
        .err_pulse (b_pulse),
        .err_cnt   (b_err),
        .zero_err  (b_zero),
        .seg0      (b_seg0),
        .seg1      (b_seg1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Active-low hex digits, written out independently of the RTL table
    logic [7:0] seg_lo [0:15] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

    typedef struct {
        bit          sel;
        bit          lk;
        bit          pl;
        bit          ze;
        logic [15:0] ec;
        logic [7:0]  s0;
        logic [7:0]  s1;
        string       nm;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   vld_d   = 1'b0;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] nxt(input logic [7:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[4];
        return {fb, s[7:1]};
    endfunction

    always @(posedge clk) vld_d <= in_valid;

    // Monitor: one expectation per beat, checked the cycle after
    always @(negedge clk) begin
        if (vld_d) begin
            if (q.size() == 0) begin
                chk("sb_underflow", 16'd1, 16'd0);
            end else begin
                e = q.pop_front();
                if (!e.sel) begin
                    chk({e.nm, ".locked"}, 16'(a_locked), 16'(e.lk));
                    chk({e.nm, ".pulse"},  16'(a_pulse),  16'(e.pl));
                    chk({e.nm, ".err"},    a_err,         e.ec);
                    chk({e.nm, ".zero"},   16'(a_zero),   16'(e.ze));
                    chk({e.nm, ".seg0"},   16'(a_seg0),   16'(e.s0));
                    chk({e.nm, ".seg1"},   16'(a_seg1),   16'(e.s1));
                end else begin
                    chk({e.nm, ".locked"}, 16'(b_locked), 16'(e.lk));
                    chk({e.nm, ".pulse"},  16'(b_pulse),  16'(e.pl));
                    chk({e.nm, ".err"},    16'(b_err),    e.ec);
                    chk({e.nm, ".zero"},   16'(b_zero),   16'(e.ze));
                    chk({e.nm, ".seg0"},   16'(b_seg0),   16'(e.s0));
                    chk({e.nm, ".seg1"},   16'(b_seg1),   16'(e.s1));
                end
            end
        end else begin
            chk("idle_pulse_a", 16'(a_pulse), 16'd0);
            chk("idle_pulse_b", 16'(b_pulse), 16'd0);
        end
    end

    task automatic beat(input bit s, input logic [7:0] d, input bit clr,
                        input bit lk, input bit pl, input logic [15:0] ec,
                        input bit ze, input logic [7:0] s0,
                        input logic [7:0] s1, input string nm);
        exp_t x;
        @(negedge clk);
        sel      = s;
        in_valid = 1'b1;
        in_data  = d;
        clr_err  = clr;
        x.sel = s; x.lk = lk; x.pl = pl; x.ze = ze;
        x.ec = ec; x.s0 = s0; x.s1 = s1; x.nm = nm;
        q.push_back(x);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            clr_err  = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] m, x, d, ecb, prev;
        int         nerr, run;
        exp_t       r;

        rst = 1'b1; in_valid = 1'b0; sel = 1'b0;
        in_data = 8'h00; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst.locked", 16'(a_locked), 16'd0);
        chk("rst.pulse",  16'(a_pulse),  16'd0);
        chk("rst.err",    a_err,         16'd0);
        chk("rst.zero",   16'(a_zero),   16'd0);
        chk("rst.seg0",   16'(a_seg0),   16'h03);
        chk("rst.seg1",   16'(a_seg1),   16'h03);

        // Lock on 01,80,40,20
        beat(0, 8'h01, 0, 0, 0, 0, 0, 8'h03, 8'h03, "lock01");
        beat(0, 8'h80, 0, 0, 0, 0, 0, 8'h03, 8'h03, "lock80");
        beat(0, 8'h40, 0, 0, 0, 0, 0, 8'h03, 8'h03, "lock40");
        beat(0, 8'h20, 0, 1, 0, 0, 0, 8'h03, 8'h03, "lock20");
        idle(3);
        chk("gap.locked", 16'(a_locked), 16'd1);

        // Single error: FF in place of 88
        beat(0, 8'h10, 0, 1, 0, 0, 0, 8'h03, 8'h03, "se10");
        beat(0, 8'hFF, 0, 1, 1, 1, 0, 8'h03, 8'h03, "seFF");
        beat(0, 8'hC4, 0, 1, 0, 1, 0, 8'h9F, 8'h03, "seC4");
        beat(0, 8'hE2, 0, 1, 0, 1, 0, 8'h9F, 8'h03, "seE2");

        // Loss: expected 71 then 38; two misses drop lock
        beat(0, 8'h55, 0, 1, 1, 2, 0, 8'h9F, 8'h03, "loss55");
        beat(0, 8'hAA, 0, 0, 1, 3, 0, 8'h25, 8'h03, "lossAA");
        beat(0, 8'h54, 0, 0, 0, 3, 0, 8'h0D, 8'h03, "re54");
        beat(0, 8'h2A, 0, 0, 0, 3, 0, 8'h0D, 8'h03, "re2A");
        beat(0, 8'h95, 0, 0, 0, 3, 0, 8'h0D, 8'h03, "re95");
        beat(0, 8'hCA, 0, 1, 0, 3, 0, 8'h0D, 8'h03, "reCA");

        // Zero while locked is an ordinary mismatch (expected E5)
        beat(0, 8'h00, 0, 1, 1, 4, 1, 8'h0D, 8'h03, "lz00");
        beat(0, 8'h72, 0, 1, 0, 4, 1, 8'h99, 8'h03, "lz72");

        // Standalone clear
        @(negedge clk);
        in_valid = 1'b0; clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("clr.err",    a_err,         16'd0);
        chk("clr.zero",   16'(a_zero),   16'd0);
        chk("clr.locked", 16'(a_locked), 16'd1);
        @(negedge clk);
        chk("clr.seg0",   16'(a_seg0),   16'h03);

        // Clear coinciding with an error beat (expected B9)
        beat(0, 8'h11, 1, 1, 1, 0, 0, 8'h03, 8'h03, "ce11");
        beat(0, 8'hDC, 0, 1, 0, 0, 0, 8'h03, 8'h03, "ceDC");
        beat(0, 8'h11, 0, 1, 1, 1, 0, 8'h03, 8'h03, "ce11b");
        beat(0, 8'h77, 0, 1, 0, 1, 0, 8'h9F, 8'h03, "ce77");

        // Reset with an in-flight beat
        @(negedge clk);
        rst = 1'b1; sel = 1'b0; in_valid = 1'b1; in_data = 8'h11;
        r.sel = 0; r.lk = 0; r.pl = 0; r.ze = 0;
        r.ec = 0; r.s0 = 8'h03; r.s1 = 8'h03; r.nm = "midrst";
        q.push_back(r);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;

        // Zeros in HUNT never lock
        beat(0, 8'h00, 0, 0, 0, 0, 1, 8'h03, 8'h03, "hz0");
        beat(0, 8'h00, 0, 0, 0, 0, 1, 8'h03, 8'h03, "hz1");
        beat(0, 8'h00, 0, 0, 0, 0, 1, 8'h03, 8'h03, "hz2");
        beat(0, 8'h00, 0, 0, 0, 0, 1, 8'h03, 8'h03, "hz3");
        idle(2);
        chk("hz.locked", 16'(a_locked), 16'd0);
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("hz.clr_zero", 16'(a_zero), 16'd0);

        // Lock with idle gaps between beats
        beat(0, 8'h01, 0, 0, 0, 0, 0, 8'h03, 8'h03, "g01");
        idle(2);
        beat(0, 8'h80, 0, 0, 0, 0, 0, 8'h03, 8'h03, "g80");
        idle(2);
        beat(0, 8'h40, 0, 0, 0, 0, 0, 8'h03, 8'h03, "g40");
        idle(2);
        chk("g.unlocked", 16'(a_locked), 16'd0);
        beat(0, 8'h20, 0, 1, 0, 0, 0, 8'h03, 8'h03, "g20");
        idle(3);
        chk("g.locked", 16'(a_locked), 16'd1);

        // Saturation on instance B
        beat(1, 8'h01, 0, 0, 0, 0, 0, 8'h03, 8'h03, "b01");
        beat(1, 8'h80, 0, 0, 0, 0, 0, 8'h03, 8'h03, "b80");
        beat(1, 8'h40, 0, 0, 0, 0, 0, 8'h03, 8'h03, "b40");
        beat(1, 8'h20, 0, 1, 0, 0, 0, 8'h03, 8'h03, "b20");
        m = 8'h20; ecb = 8'h00; nerr = 0; run = 0;
        while (nerr < 300) begin
            x = nxt(m);
            m = x;
            prev = ecb;
            if (run == 14) begin
                run = 0;
                beat(1, x, 0, 1, 0, 16'(ecb), 0,
                     seg_lo[prev[3:0]], seg_lo[prev[7:4]], "bgood");
            end else begin
                d = x ^ 8'h80;
                if (d == 8'h00) d = 8'h81;
                if (ecb != 8'hFF) ecb = ecb + 8'd1;
                run++;
                nerr++;
                beat(1, d, 0, 1, 1, 16'(ecb), 0,
                     seg_lo[prev[3:0]], seg_lo[prev[7:4]], "berr");
            end
        end
        idle(2);
        chk("sat.err", 16'(b_err), 16'h00FF);
        chk("sat.locked", 16'(b_locked), 16'd1);
        x = nxt(m);
        d = x ^ 8'h80;
        if (d == 8'h00) d = 8'h81;
        beat(1, d, 1, 1, 1, 0, 0, 8'h71, 8'h71, "satclr");
        idle(2);
        chk("satclr.seg0", 16'(b_seg0), 16'h03);

        idle(2);
        chk("sb_empty", 16'(q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
